// File: rtl/wlm_sched.sv
// Round-robin scheduler for two request streams sharing one wlm pipeline.
// Owns qH, drains the pipeline before a reload, and steers results into per-port FIFOs.
module wlm_sched #(
  parameter int LOGQ  = 60,
  parameter int LOGQH = 43,
  parameter int LAT   = 4,
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [LOGQH-1:0]   cfg_qH,
  input  logic               a_valid,
  output logic               a_ready,
  input  logic [2*LOGQ-1:0]  a_C,
  input  logic               b_valid,
  output logic               b_ready,
  input  logic [2*LOGQ-1:0]  b_C,
  output logic               ra_valid,
  input  logic               ra_ready,
  output logic [LOGQ-1:0]    ra_T,
  output logic               rb_valid,
  input  logic               rb_ready,
  output logic [LOGQ-1:0]    rb_T,
  output logic [LOGQH-1:0]   wlm_qH,
  output logic [2*LOGQ-1:0]  wlm_C,
  input  logic [LOGQ-1:0]    wlm_T,
  output logic               busy
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {UNCFG, RUN, DRAIN, LOAD} state_t;

  state_t state, state_nxt;

  // Stage 0 lines up with wlm_C, so stage LAT lines up with wlm_T.
  logic [LAT:0] tag_v, tag_p;

  logic            last_b;
  logic [1:0]      cand, grant, push, pop, nonempty;
  logic [CW-1:0]   cnt [2];
  logic [CW-1:0]   occ [2];
  logic [PW-1:0]   wptr [2];
  logic [PW-1:0]   rptr [2];
  logic [LOGQ-1:0] mem [2][DEPTH];

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
    return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= UNCFG;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cfg_ready = 1'b0;
    case (state)
      UNCFG: if (cfg_valid) state_nxt = LOAD;
      RUN:   if (cfg_valid) state_nxt = DRAIN;
      DRAIN: if (tag_v == '0) state_nxt = LOAD;
      LOAD: begin
        cfg_ready = 1'b1;
        state_nxt = RUN;
      end
      default: state_nxt = UNCFG;
    endcase
  end

  assign cand[0]  = a_valid && (state == RUN) && (cnt[0] < CW'(DEPTH));
  assign cand[1]  = b_valid && (state == RUN) && (cnt[1] < CW'(DEPTH));
  assign grant[0] = cand[0] && (!cand[1] || last_b);
  assign grant[1] = cand[1] && (!cand[0] || !last_b);
  assign a_ready  = grant[0];
  assign b_ready  = grant[1];

  assign push[0]     = tag_v[LAT] & ~tag_p[LAT];
  assign push[1]     = tag_v[LAT] &  tag_p[LAT];
  assign nonempty[0] = (occ[0] != '0);
  assign nonempty[1] = (occ[1] != '0);
  assign pop         = nonempty & {rb_ready, ra_ready};

  assign ra_valid = nonempty[0];
  assign rb_valid = nonempty[1];
  assign ra_T     = nonempty[0] ? mem[0][rptr[0]] : '0;
  assign rb_T     = nonempty[1] ? mem[1][rptr[1]] : '0;
  assign busy     = (|tag_v) || (|nonempty);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wlm_C  <= '0;
      wlm_qH <= '0;
      tag_v  <= '0;
      tag_p  <= '0;
      last_b <= 1'b1;
    end else begin
      tag_v <= {tag_v[LAT-1:0], |grant};
      tag_p <= {tag_p[LAT-1:0], grant[1]};
      if (|grant) begin
        wlm_C  <= grant[1] ? b_C : a_C;
        last_b <= grant[1];
      end
      if (state == LOAD) wlm_qH <= cfg_qH;
    end
  end

  // Credits cover in-flight plus queued results, so a push never finds its FIFO full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int p = 0; p < 2; p++) begin
        cnt[p]  <= '0;
        occ[p]  <= '0;
        wptr[p] <= '0;
        rptr[p] <= '0;
      end
    end else begin
      for (int p = 0; p < 2; p++) begin
        cnt[p] <= cnt[p] + CW'(grant[p]) - CW'(pop[p]);
        occ[p] <= occ[p] + CW'(push[p]) - CW'(pop[p]);
        if (push[p]) wptr[p] <= ptr_inc(wptr[p]);
        if (pop[p])  rptr[p] <= ptr_inc(rptr[p]);
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int p = 0; p < 2; p++) begin
      if (push[p]) mem[p][wptr[p]] <= wlm_T;
    end
  end

endmodule

// File: tb/tb_wlm_sched.sv
// Bench for wlm_sched: directed scenarios plus random traffic against a
// queue-based model of issue order, credits, result latency and round-robin.
module tb_wlm_sched;
  localparam int LOGQ  = 60;
  localparam int LOGQH = 43;
  localparam int LAT   = 4;
  localparam int DEPTH = 2;

  logic              clk = 1'b0, rst = 1'b1;
  logic              cfg_valid = 1'b0, cfg_ready;
  logic [LOGQH-1:0]  cfg_qH = '0;
  logic              a_valid = 1'b0, a_ready, b_valid = 1'b0, b_ready;
  logic [2*LOGQ-1:0] a_C = '0, b_C = '0;
  logic              ra_valid, ra_ready = 1'b0, rb_valid, rb_ready = 1'b0;
  logic [LOGQ-1:0]   ra_T, rb_T, wlm_T;
  logic [LOGQH-1:0]  wlm_qH;
  logic [2*LOGQ-1:0] wlm_C;
  logic              busy;

  always #5 clk = ~clk;

  wlm_sched #(.LOGQ(LOGQ), .LOGQH(LOGQH), .LAT(LAT), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_qH(cfg_qH),
    .a_valid(a_valid), .a_ready(a_ready), .a_C(a_C),
    .b_valid(b_valid), .b_ready(b_ready), .b_C(b_C),
    .ra_valid(ra_valid), .ra_ready(ra_ready), .ra_T(ra_T),
    .rb_valid(rb_valid), .rb_ready(rb_ready), .rb_T(rb_T),
    .wlm_qH(wlm_qH), .wlm_C(wlm_C), .wlm_T(wlm_T), .busy(busy)
  );

  // wlm stand-in: pure LAT-cycle delay of the low operand half
  logic [LOGQ-1:0] sd [LAT];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) sd[i] <= '0;
    end else begin
      sd[0] <= wlm_C[LOGQ-1:0];
      for (int i = 1; i < LAT; i++) sd[i] <= sd[i-1];
    end
  end
  assign wlm_T = sd[LAT-1];

  int total = 0, bad = 0;
  int cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  logic [LOGQ-1:0]   qa[$], qb[$];
  int                ta[$], tq[$];
  int                gseq[$];
  int                cred_a, cred_b, iss_a, iss_b, na = 1, nb = 1;
  bit                last_b_m, hs_a, hs_b, auto_data;
  logic [2*LOGQ-1:0] exp_wc;
  logic [LOGQH-1:0]  cur_qh;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clr();
    qa.delete(); qb.delete(); ta.delete(); tq.delete();
    cred_a = 0; cred_b = 0; last_b_m = 1'b1; exp_wc = '0; cur_qh = '0;
  endtask

  function automatic int inflight();
    int n = 0;
    foreach (ta[i]) if (ta[i] + LAT + 1 > cyc_n) n++;
    foreach (tq[i]) if (tq[i] + LAT + 1 > cyc_n) n++;
    return n;
  endfunction

  task automatic set_data();
    a_C = {28'($urandom), 32'($urandom), 60'(na)};
    b_C = {28'($urandom), 32'($urandom), 60'(nb + 32'h1000)};
  endtask

  // one cycle of observation: check against the model, then account handshakes
  task automatic mon(input bit run_exp);
    bit ca, cb, ea, eb, rva, rvb;
    @(negedge clk);
    ca  = a_valid && run_exp && (cred_a < DEPTH);
    cb  = b_valid && run_exp && (cred_b < DEPTH);
    ea  = ca && (!cb || last_b_m);
    eb  = cb && (!ca || !last_b_m);
    rva = (qa.size() > 0) && (ta[0] + LAT + 1 <= cyc_n);
    rvb = (qb.size() > 0) && (tq[0] + LAT + 1 <= cyc_n);
    chk("a_ready", a_ready, ea);
    chk("b_ready", b_ready, eb);
    chk("busy", busy, (cred_a + cred_b) != 0);
    chk("wlm_C", wlm_C, exp_wc);
    chk("ra_valid", ra_valid, rva);
    chk("rb_valid", rb_valid, rvb);
    if (ra_valid && qa.size() > 0) chk("ra_T", ra_T, qa[0]);
    if (rb_valid && qb.size() > 0) chk("rb_T", rb_T, qb[0]);
    hs_a = a_valid && a_ready;
    hs_b = b_valid && b_ready;
    if (hs_a) begin
      qa.push_back(a_C[LOGQ-1:0]); ta.push_back(cyc_n + 1);
      cred_a++; iss_a++; last_b_m = 1'b0; exp_wc = a_C; gseq.push_back(0);
    end
    if (hs_b) begin
      qb.push_back(b_C[LOGQ-1:0]); tq.push_back(cyc_n + 1);
      cred_b++; iss_b++; last_b_m = 1'b1; exp_wc = b_C; gseq.push_back(1);
    end
    if (ra_valid && ra_ready && qa.size() > 0) begin
      void'(qa.pop_front()); void'(ta.pop_front()); cred_a--;
    end
    if (rb_valid && rb_ready && qb.size() > 0) begin
      void'(qb.pop_front()); void'(tq.pop_front()); cred_b--;
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic adv();
    step();
    if (auto_data) begin
      if (hs_a) na++;
      if (hs_b) nb++;
      set_data();
    end
  endtask

  task automatic cyc(input bit run_exp);
    mon(run_exp);
    adv();
  endtask

  task automatic do_cfg(input logic [LOGQH-1:0] qh);
    cfg_qH = qh; cfg_valid = 1'b1;
    mon(0); chk("cfg_ready_uncfg", cfg_ready, 0); step();
    mon(0); chk("cfg_ready_load", cfg_ready, 1); chk("qh_before", wlm_qH, cur_qh); step();
    cfg_valid = 1'b0; a_valid = 1'b0; b_valid = 1'b0; cur_qh = qh;
    chk("qh_after", wlm_qH, qh);
  endtask

  task automatic drain(input int n);
    a_valid = 1'b0; b_valid = 1'b0; ra_ready = 1'b1; rb_ready = 1'b1;
    repeat (n) cyc(1);
    chk("drain_a", qa.size(), 0);
    chk("drain_b", qb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ia, ib, got;
    model_clr();
    // reset values
    a_valid = 1'b1;
    #12;
    chk("rst_a_ready", a_ready, 0); chk("rst_b_ready", b_ready, 0);
    chk("rst_ra_valid", ra_valid, 0); chk("rst_rb_valid", rb_valid, 0);
    chk("rst_cfg_ready", cfg_ready, 0); chk("rst_busy", busy, 0);
    chk("rst_wlm_C", wlm_C, 0); chk("rst_wlm_qH", wlm_qH, 0);
    @(posedge clk); #1; rst = 1'b0;
    cyc(0);
    do_cfg(43'h1234);

    // both ports saturated: grants alternate starting with A
    auto_data = 1'b1; set_data();
    a_valid = 1'b1; b_valid = 1'b1; ra_ready = 1'b1; rb_ready = 1'b1;
    gseq.delete();
    repeat (16) cyc(1);
    chk("alt_count", gseq.size() >= 6, 1);
    if (gseq.size() >= 6)
      for (int i = 0; i < 6; i++) chk("alt_order", gseq[i], i % 2);
    drain(12);

    // single op latency
    auto_data = 1'b0;
    a_C = 120'h5; a_valid = 1'b1; ra_ready = 1'b0;
    mon(1); chk("lat_a_ready", a_ready, 1); step();
    a_valid = 1'b0;
    for (int k = 0; k <= 5; k++) begin
      mon(1);
      chk("lat_ra_valid", ra_valid, k == 5);
      if (k < 5) step();
    end
    chk("lat_ra_T", ra_T, 60'h5);
    step();
    ra_ready = 1'b1; mon(1); step();
    ra_ready = 1'b0; mon(1);
    chk("lat_busy_after_pop", busy, 0);
    chk("lat_ra_valid_after_pop", ra_valid, 0);
    step();

    // credit limit on A while its results are not consumed
    auto_data = 1'b1; set_data();
    ia = iss_a; ib = iss_b;
    a_valid = 1'b1; b_valid = 1'b1; ra_ready = 1'b0; rb_ready = 1'b1;
    repeat (20) cyc(1);
    chk("cr_a_issues", iss_a - ia, 2);
    chk("cr_b_served", (iss_b - ib) > 0, 1);
    mon(1); chk("cr_a_blocked", a_ready, 0); adv();
    ra_ready = 1'b1; cyc(1); ra_ready = 1'b0;
    ia = iss_a;
    repeat (20) cyc(1);
    chk("cr_a_one_more", iss_a - ia, 1);
    drain(12);

    // reload with three ops in flight
    a_valid = 1'b1; b_valid = 1'b1;
    repeat (3) cyc(1);
    chk("rl_inflight", inflight(), 3);
    a_valid = 1'b0; b_valid = 1'b0;
    cfg_qH = 43'h0ABC; cfg_valid = 1'b1;
    cyc(1);
    a_valid = 1'b1; b_valid = 1'b1;
    got = 0;
    for (int i = 0; i < 30 && got == 0; i++) begin
      mon(0);
      chk("rl_qh_hold", wlm_qH, cur_qh);
      if (cfg_ready) begin
        got = 1;
        chk("rl_load_empty", inflight(), 0);
      end
      step();
    end
    chk("rl_load_seen", got, 1);
    chk("rl_qh_new", wlm_qH, 43'h0ABC);
    cur_qh = 43'h0ABC; cfg_valid = 1'b0;
    mon(1); chk("rl_resume", a_ready | b_ready, 1); adv();
    drain(12);

    // random traffic
    for (int i = 0; i < 300; i++) begin
      a_valid  = ($urandom_range(0, 3) != 0);
      b_valid  = ($urandom_range(0, 3) != 0);
      ra_ready = ($urandom_range(0, 2) != 0);
      rb_ready = ($urandom_range(0, 2) != 0);
      cyc(1);
    end
    drain(14);

    // async reset with two ops in flight
    a_valid = 1'b1; b_valid = 1'b0; ra_ready = 1'b0;
    cyc(1); cyc(1);
    #2 rst = 1'b1;
    #1;
    chk("arst_a_ready", a_ready, 0); chk("arst_b_ready", b_ready, 0);
    chk("arst_ra_valid", ra_valid, 0); chk("arst_rb_valid", rb_valid, 0);
    chk("arst_cfg_ready", cfg_ready, 0); chk("arst_busy", busy, 0);
    chk("arst_ra_T", ra_T, 0); chk("arst_rb_T", rb_T, 0);
    chk("arst_wlm_C", wlm_C, 0); chk("arst_wlm_qH", wlm_qH, 0);
    model_clr();
    @(posedge clk); @(posedge clk); #1; rst = 1'b0;
    ra_ready = 1'b1;
    repeat (12) cyc(0);
    do_cfg(43'h7_0000_0321);

    // first tie after reset goes to A
    a_valid = 1'b1; b_valid = 1'b1;
    mon(1);
    chk("tie_a", a_ready, 1);
    chk("tie_b", b_ready, 0);
    adv();
    for (int i = 0; i < 100; i++) begin
      a_valid  = ($urandom_range(0, 1) != 0);
      b_valid  = ($urandom_range(0, 1) != 0);
      ra_ready = ($urandom_range(0, 3) != 0);
      rb_ready = ($urandom_range(0, 3) != 0);
      cyc(1);
    end
    drain(14);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
